// File: rtl/seven_segment_capture.sv
// seven_segment_capture: watches a multiplexed seven-segment display bus
// (active-low anodes and cathodes) and rebuilds the 16-bit hex value,
// per-digit enable, decimal points and glyph errors being shown.
module seven_segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] data_out,
  output logic [3:0]  digit_on,
  output logic [3:0]  dp_out,
  output logic [3:0]  digit_error,
  output logic        frame_valid,
  output logic        capture_valid
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [3:0]  prev_anode;
  logic [7:0]  dwell;
  logic [7:0]  dwell_nxt;
  logic        legal;
  logic        stable;
  logic        sample;
  logic [1:0]  idx;

  logic [6:0]  pat;
  logic [3:0]  s_nib;
  logic        s_on;
  logic        s_err;
  logic        s_dp;

  logic [3:0]  seen;
  logic [15:0] sh_nib;
  logic [3:0]  sh_on;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_err;
  logic [15:0] seen_nib;

  // Anode legality and digit index: exactly one anode driven low.
  always_comb begin
    legal = 1'b0;
    idx   = 2'd0;
    unique case (anode)
      4'b1110: begin legal = 1'b1; idx = 2'd0; end
      4'b1101: begin legal = 1'b1; idx = 2'd1; end
      4'b1011: begin legal = 1'b1; idx = 2'd2; end
      4'b0111: begin legal = 1'b1; idx = 2'd3; end
      default: begin legal = 1'b0; idx = 2'd0; end
    endcase
  end

  // Dwell counter next state and the single sample point per dwell.
  // The saturation guard stops a held anode from resampling once the
  // counter pins at 255 (matters when SETTLE_CYCLES is 255).
  always_comb begin
    stable = legal && (anode == prev_anode);
    if (!legal)
      dwell_nxt = '0;
    else if (!stable)
      dwell_nxt = 8'd1;
    else if (dwell != 8'hFF)
      dwell_nxt = dwell + 8'd1;
    else
      dwell_nxt = dwell;
    sample = legal && (dwell_nxt == SETTLE) && !(stable && (dwell == 8'hFF));
  end

  // Glyph decode of the current cathode pattern.
  always_comb begin
    pat   = ~segment[6:0];
    s_dp  = ~segment[7];
    s_on  = 1'b1;
    s_err = 1'b0;
    s_nib = 4'h0;
    case (pat)
      7'h3F: s_nib = 4'h0;
      7'h06: s_nib = 4'h1;
      7'h5B: s_nib = 4'h2;
      7'h4F: s_nib = 4'h3;
      7'h66: s_nib = 4'h4;
      7'h6D: s_nib = 4'h5;
      7'h7D: s_nib = 4'h6;
      7'h07: s_nib = 4'h7;
      7'h7F: s_nib = 4'h8;
      7'h6F: s_nib = 4'h9;
      7'h77: s_nib = 4'hA;
      7'h7C: s_nib = 4'hB;
      7'h39: s_nib = 4'hC;
      7'h5E: s_nib = 4'hD;
      7'h79: s_nib = 4'hE;
      7'h71: s_nib = 4'hF;
      7'h00: s_on  = 1'b0;
      default: s_err = 1'b1;
    endcase
  end

  // Expand the seen mask to nibble width so unseen digits publish as zero.
  always_comb begin
    seen_nib = '0;
    for (int unsigned i = 0; i < 4; i++)
      seen_nib[i*4 +: 4] = {4{seen[i]}};
  end

  // Dwell tracking, shadow capture and frame publication.
  // A repeated digit index closes the frame: shadows are published and
  // the same sample seeds the next frame's shadow for that digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_anode    <= '1;
      dwell         <= '0;
      seen          <= '0;
      sh_nib        <= '0;
      sh_on         <= '0;
      sh_dp         <= '0;
      sh_err        <= '0;
      data_out      <= '0;
      digit_on      <= '0;
      dp_out        <= '0;
      digit_error   <= '0;
      frame_valid   <= 1'b0;
      capture_valid <= 1'b0;
    end else begin
      prev_anode  <= anode;
      dwell       <= dwell_nxt;
      frame_valid <= 1'b0;
      if (sample) begin
        sh_nib[idx*4 +: 4] <= s_nib;
        sh_on[idx]         <= s_on;
        sh_dp[idx]         <= s_dp;
        sh_err[idx]        <= s_err;
        if (!seen[idx]) begin
          seen[idx] <= 1'b1;
        end else begin
          data_out      <= sh_nib & seen_nib;
          digit_on      <= sh_on & seen;
          dp_out        <= sh_dp & seen;
          digit_error   <= sh_err & seen;
          frame_valid   <= 1'b1;
          capture_valid <= 1'b1;
          seen          <= 4'b0001 << idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with SETTLE_CYCLES = 4.
module tb_seven_segment_capture;

  logic        clk;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic [15:0] data_out;
  logic [3:0]  digit_on;
  logic [3:0]  dp_out;
  logic [3:0]  digit_error;
  logic        frame_valid;
  logic        capture_valid;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  logic fv_prev = 1'b0;
  logic fv_double = 1'b0;

  seven_segment_capture #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .anode(anode), .segment(segment),
    .data_out(data_out), .digit_on(digit_on), .dp_out(dp_out),
    .digit_error(digit_error), .frame_valid(frame_valid),
    .capture_valid(capture_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid pulses and flag back-to-back pulses.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count = fv_count + 1;
      if (fv_prev) fv_double = 1'b1;
    end
    fv_prev = frame_valid;
  end

  function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dp);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
      4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
      4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
      4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
    endcase
    return ~{dp, g};
  endfunction

  task automatic show(input int d, input logic [7:0] seg, input int n);
    anode   = ~(4'b0001 << d);
    segment = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    anode   = 4'b1111;
    segment = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    anode   = 4'b1111;
    segment = 8'hFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid} !== 30'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid}); end
    blank(100);
    checks++; if ({data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid} !== 30'h0) begin
      errors++; $display("FAIL idle_outputs got %h want 0", {data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid}); end
    checks++; if (fv_count !== 0) begin errors++; $display("FAIL idle_frames got %0d want 0", fv_count); end
  endtask

  task automatic test_basic_scan();
    int f0;
    logic [7:0] s0;
    do_reset();
    f0 = fv_count;
    s0 = seg_of(4'h4, 1'b0);
    show(0, s0, 64);
    show(1, seg_of(4'h3, 1'b0), 64);
    show(2, seg_of(4'h2, 1'b0), 64);
    show(3, seg_of(4'h1, 1'b0), 64);
    checks++; if (capture_valid !== 1'b0) begin errors++; $display("FAIL pre_close_capture got %b want 0", capture_valid); end
    // closing digit 0: publication lands on the 4th edge of the dwell
    anode = 4'b1110; segment = s0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++; if (frame_valid !== (k == 4)) begin
        errors++; $display("FAIL latency_fv cycle %0d got %b want %b", k, frame_valid, (k == 4)); end
    end
    show(0, s0, 59);
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL scan_data got %h want 1234", data_out); end
    checks++; if (digit_on !== 4'hF) begin errors++; $display("FAIL scan_on got %h want f", digit_on); end
    checks++; if ({dp_out, digit_error} !== 8'h00) begin errors++; $display("FAIL scan_dp_err got %h want 00", {dp_out, digit_error}); end
    checks++; if (capture_valid !== 1'b1) begin errors++; $display("FAIL scan_capture got %b want 1", capture_valid); end
    show(1, seg_of(4'h3, 1'b0), 64);
    show(2, seg_of(4'h2, 1'b0), 64);
    show(3, seg_of(4'h1, 1'b0), 64);
    show(0, s0, 64);
    checks++; if (fv_count - f0 !== 2) begin errors++; $display("FAIL scan_frames got %0d want 2", fv_count - f0); end
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL scan2_data got %h want 1234", data_out); end
  endtask

  task automatic test_blank_digit();
    do_reset();
    show(0, seg_of(4'hF, 1'b0), 64);
    show(1, seg_of(4'h0, 1'b1), 64);
    blank(64);
    show(3, seg_of(4'h0, 1'b0), 64);
    show(0, seg_of(4'hF, 1'b0), 64);
    checks++; if (data_out !== 16'h000F) begin errors++; $display("FAIL blank_data got %h want 000f", data_out); end
    checks++; if (digit_on !== 4'b1011) begin errors++; $display("FAIL blank_on got %b want 1011", digit_on); end
    checks++; if (dp_out !== 4'b0010) begin errors++; $display("FAIL blank_dp got %b want 0010", dp_out); end
    checks++; if (digit_error !== 4'b0000) begin errors++; $display("FAIL blank_err got %b want 0000", digit_error); end
  endtask

  task automatic test_glitch();
    int f0;
    do_reset();
    f0 = fv_count;
    show(0, seg_of(4'h5, 1'b0), 64);
    show(1, seg_of(4'h8, 1'b0), 3);
    anode = 4'b1100; segment = seg_of(4'h6, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    show(2, seg_of(4'h7, 1'b0), 4);
    show(3, seg_of(4'h9, 1'b0), 64);
    checks++; if (fv_count !== f0) begin errors++; $display("FAIL glitch_early_frame got %0d want %0d", fv_count, f0); end
    show(0, seg_of(4'h5, 1'b0), 64);
    checks++; if (data_out !== 16'h9705) begin errors++; $display("FAIL glitch_data got %h want 9705", data_out); end
    checks++; if (digit_on !== 4'b1101) begin errors++; $display("FAIL glitch_on got %b want 1101", digit_on); end
    checks++; if (dp_out !== 4'b0000) begin errors++; $display("FAIL glitch_dp got %b want 0000", dp_out); end
    checks++; if (fv_count - f0 !== 1) begin errors++; $display("FAIL glitch_frames got %0d want 1", fv_count - f0); end
  endtask

  task automatic test_error_then_reset();
    int f0;
    do_reset();
    show(0, seg_of(4'h1, 1'b0), 64);
    show(1, 8'hB6, 64);
    show(2, seg_of(4'h2, 1'b0), 64);
    show(3, seg_of(4'h3, 1'b0), 64);
    show(0, seg_of(4'h1, 1'b0), 64);
    checks++; if (data_out !== 16'h3201) begin errors++; $display("FAIL err_data got %h want 3201", data_out); end
    checks++; if (digit_error !== 4'b0010) begin errors++; $display("FAIL err_flags got %b want 0010", digit_error); end
    checks++; if (digit_on !== 4'b1111) begin errors++; $display("FAIL err_on got %b want 1111", digit_on); end
    // partial frame, then reset mid-frame
    show(1, seg_of(4'hE, 1'b1), 64);
    show(2, seg_of(4'hF, 1'b0), 64);
    do_reset();
    checks++; if ({data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid} !== 30'h0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0", {data_out, digit_on, dp_out, digit_error, frame_valid, capture_valid}); end
    f0 = fv_count;
    show(0, seg_of(4'h6, 1'b0), 64);
    show(1, seg_of(4'h7, 1'b0), 64);
    show(2, seg_of(4'h8, 1'b0), 64);
    show(3, seg_of(4'h9, 1'b0), 64);
    checks++; if (fv_count !== f0) begin errors++; $display("FAIL midreset_early_frame got %0d want %0d", fv_count, f0); end
    show(0, seg_of(4'h6, 1'b0), 64);
    checks++; if (data_out !== 16'h9876) begin errors++; $display("FAIL midreset_data got %h want 9876", data_out); end
    checks++; if ({dp_out, digit_error, digit_on} !== 12'h00F) begin errors++; $display("FAIL midreset_flags got %h want 00f", {dp_out, digit_error, digit_on}); end
    checks++; if (fv_count - f0 !== 1) begin errors++; $display("FAIL midreset_frames got %0d want 1", fv_count - f0); end
  endtask

  task automatic test_stuck_anode();
    int f0;
    do_reset();
    f0 = fv_count;
    show(1, seg_of(4'h3, 1'b0), 100);
    show(1, seg_of(4'h7, 1'b0), 250);
    checks++; if (fv_count !== f0) begin errors++; $display("FAIL stuck_frames got %0d want %0d", fv_count, f0); end
    checks++; if ({data_out, capture_valid} !== 17'h0) begin errors++; $display("FAIL stuck_hold got %h want 0", {data_out, capture_valid}); end
    show(2, seg_of(4'hA, 1'b0), 64);
    show(3, seg_of(4'hB, 1'b0), 64);
    show(0, seg_of(4'hC, 1'b0), 64);
    show(1, seg_of(4'h7, 1'b0), 64);
    checks++; if (data_out !== 16'hBA3C) begin errors++; $display("FAIL stuck_data got %h want ba3c", data_out); end
    checks++; if (fv_count - f0 !== 1) begin errors++; $display("FAIL stuck_close got %0d want 1", fv_count - f0); end
  endtask

  initial begin
    reset = 1'b1; anode = 4'b1111; segment = 8'hFF;
    test_reset();
    test_basic_scan();
    test_blank_digit();
    test_glitch();
    test_error_then_reset();
    test_stuck_anode();
    checks++; if (fv_double !== 1'b0) begin errors++; $display("FAIL fv_back_to_back got %b want 0", fv_double); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Reader for the multiplexed seven-segment display bus. It watches the anode/segment outputs of the display controller and reconstructs the 16-bit hex value, per-digit enable and decimal points being shown.
- Used in simulation benches and on-board self-check, so counter/display designs can be verified against the physical display signals rather than internal nets.
- Same clock domain as the display controller; no input synchronizer.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles an anode value must hold before segment is sampled (legal range 1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- anode  input  4  display anodes, active-low; anode[0] = rightmost digit (data bits [3:0])
- segment  input  8  cathodes, active-low; segment[0..6] = a..g, segment[7] = dp
- data_out  output  16  captured value; nibble i from digit i
- digit_on  output  4  1 = digit i was lit with a non-blank pattern in the last frame
- dp_out  output  4  captured decimal point per digit, active-high
- digit_error  output  4  1 = digit i showed a pattern that is not a hex glyph
- frame_valid  output  1  one-cycle pulse when a new frame is published
- capture_valid  output  1  level; high after the first published frame since reset

Behaviour:
- Reset: all outputs 0, dwell counter 0, seen mask 0, shadow registers 0. Reset mid-frame discards partial data.
- An anode value is legal when exactly one bit is 0 (4'b1110, 1101, 1011, 0111); digit index = position of the 0.
- Dwell counter (8-bit, saturating):
  - Increments while anode equals its previous-cycle value and is legal.
  - Clears to 1 when anode changes to a legal value.
  - Clears to 0 on any illegal value (1111, or more than one 0).
- Sample event: occurs on the cycle the dwell count equals SETTLE_CYCLES. Exactly one sample per dwell; holding the anode longer never resamples.
- Decode on sample: p = ~segment[6:0] (bit0 = a).
  - Hex map for p: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - p = 00 (blank): nibble 0, on 0, error 0.
  - Any other unmapped pattern: nibble 0, on 1, error 1.
  - dp = ~segment[7].
- Frame tracking uses a seen[3:0] mask and shadow registers for nibble, on, dp and error.
- On a sample for digit i:
  - If seen[i] = 0: write the shadow registers for i and set seen[i].
  - If seen[i] = 1 (frame closes): on the next clock, publish the shadows to the outputs.
    - Digits with seen = 0 publish nibble 0, on 0, dp 0, err 0. This covers digits blanked via anode = 1111.
    - Pulse frame_valid for that one cycle and set capture_valid.
    - Simultaneously reset seen to only bit i and load digit i's shadows with the current sample. The closing sample starts the next frame.
- Latency: outputs and frame_valid update on the clock edge after the closing sample event.
- Outputs hold between frames. frame_valid is never high two consecutive cycles.
- An anode stuck at one legal value yields a single sample and no frame, so outputs hold.

Test Plan:
- Reset, then idle anode = 1111 for 100 cycles -> all outputs 0, no frame_valid.
- Display 16'h1234, all digits on, no dp, 64-cycle dwell per digit, scan order 0,1,2,3,0 -> frame_valid pulses once per scan.
  - Published values: data_out = 16'h1234, digit_on = 4'hF, dp_out = 0, digit_error = 0, capture_valid = 1.
- Digit 2 blanked by anode = 1111 during its slot, value 16'h0A0F, dp on digit 1 -> data_out = 16'h000F with nibble 2 = 0 and nibble 3 = 0 (digit 3 shows '0').
  - digit_on = 4'b1011, dp_out = 4'b0010.
- Anode glitch: a 3-cycle dwell with SETTLE_CYCLES = 4, then 4'b1100 for 10 cycles -> no sample taken for either; the frame is published later without those digits.
- Digit 1 driven with segment = 8'hFF-free garbage pattern p = 7'h49 -> digit_error[1] = 1, digit_on[1] = 1, nibble 1 = 0.
- Assert reset for 1 cycle mid-frame after digits 0 and 1 are captured -> all outputs 0 next cycle.
  - The next full scan publishes correct data, with the first frame_valid only after the first repeated digit index.
